// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter sharing one DDR burst port among NREQ requesters.
// Grant index, direction, length and address are latched for the whole burst.
module ddr_burst_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LEN_W  = 10,
  localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_calib_complete,
  input  logic [NREQ-1:0]        req_rd,
  input  logic [NREQ-1:0]        req_wr,
  input  logic [NREQ*LEN_W-1:0]  req_rd_len,
  input  logic [NREQ*LEN_W-1:0]  req_wr_len,
  input  logic [NREQ*ADDR_W-1:0] req_rd_addr,
  input  logic [NREQ*ADDR_W-1:0] req_wr_addr,
  input  logic [NREQ*DATA_W-1:0] req_wr_data,
  output logic [NREQ-1:0]        req_wr_data_req,
  output logic [DATA_W-1:0]      req_rd_data,
  output logic [NREQ-1:0]        req_rd_valid,
  output logic [NREQ-1:0]        req_rd_finish,
  output logic [NREQ-1:0]        req_wr_finish,
  output logic [IDW-1:0]         gnt_id,
  output logic                   busy,
  output logic                   rd_burst_req,
  output logic                   wr_burst_req,
  output logic [LEN_W-1:0]       rd_burst_len,
  output logic [LEN_W-1:0]       wr_burst_len,
  output logic [ADDR_W-1:0]      rd_burst_addr,
  output logic [ADDR_W-1:0]      wr_burst_addr,
  output logic [DATA_W-1:0]      wr_burst_data,
  input  logic                   wr_burst_data_req,
  input  logic [DATA_W-1:0]      rd_burst_data,
  input  logic                   rd_burst_data_valid,
  input  logic                   rd_burst_finish,
  input  logic                   wr_burst_finish
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_BUSY    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_ZERO    = 3'd4;

  logic [2:0]        state;
  logic [IDW-1:0]    ptr;
  logic              dir_rd;
  logic              zero_len;

  logic [LEN_W-1:0]  rd_len_a  [NREQ];
  logic [LEN_W-1:0]  wr_len_a  [NREQ];
  logic [ADDR_W-1:0] rd_addr_a [NREQ];
  logic [ADDR_W-1:0] wr_addr_a [NREQ];
  logic [DATA_W-1:0] wr_data_a [NREQ];

  logic              pick_found;
  logic              pick_rd;
  logic [IDW-1:0]    pick_idx;
  logic [IDW-1:0]    cand;
  logic [LEN_W-1:0]  pick_len;
  logic [ADDR_W-1:0] pick_addr;
  logic [IDW-1:0]    next_ptr;
  logic [NREQ-1:0]   own;
  logic              in_busy;
  logic              in_zero;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      rd_len_a[i]  = req_rd_len[i*LEN_W +: LEN_W];
      wr_len_a[i]  = req_wr_len[i*LEN_W +: LEN_W];
      rd_addr_a[i] = req_rd_addr[i*ADDR_W +: ADDR_W];
      wr_addr_a[i] = req_wr_addr[i*ADDR_W +: ADDR_W];
      wr_data_a[i] = req_wr_data[i*DATA_W +: DATA_W];
    end
  end

  // Scan starts at ptr and wraps; the first requester found wins, read before write.
  always_comb begin
    pick_found = 1'b0;
    pick_rd    = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!pick_found && (req_rd[cand] || req_wr[cand])) begin
        pick_found = 1'b1;
        pick_idx   = cand;
        pick_rd    = req_rd[cand];
      end
    end
  end

  assign pick_len  = pick_rd ? rd_len_a[pick_idx]  : wr_len_a[pick_idx];
  assign pick_addr = pick_rd ? rd_addr_a[pick_idx] : wr_addr_a[pick_idx];
  assign next_ptr  = (gnt_id == IDW'(NREQ - 1)) ? '0 : IDW'(gnt_id + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ptr           <= '0;
      gnt_id        <= '0;
      dir_rd        <= 1'b0;
      zero_len      <= 1'b0;
      rd_burst_len  <= '0;
      wr_burst_len  <= '0;
      rd_burst_addr <= '0;
      wr_burst_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (init_calib_complete && pick_found) begin
            gnt_id   <= pick_idx;
            dir_rd   <= pick_rd;
            zero_len <= (pick_len == '0);
            if (pick_rd) begin
              rd_burst_len  <= pick_len;
              rd_burst_addr <= pick_addr;
            end else begin
              wr_burst_len  <= pick_len;
              wr_burst_addr <= pick_addr;
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= zero_len ? S_ZERO : S_BUSY;
        S_BUSY: begin
          // Calibration loss is ignored here; only the matching finish ends a burst.
          if (dir_rd ? rd_burst_finish : wr_burst_finish) state <= S_RELEASE;
        end
        S_ZERO: state <= S_RELEASE;
        S_RELEASE: begin
          ptr   <= next_ptr;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    own         = '0;
    own[gnt_id] = 1'b1;
  end

  assign in_busy = (state == S_BUSY);
  assign in_zero = (state == S_ZERO);

  assign busy         = (state == S_ISSUE) || in_busy;
  assign rd_burst_req = (state == S_ISSUE) && dir_rd && !zero_len;
  assign wr_burst_req = (state == S_ISSUE) && !dir_rd && !zero_len;

  assign req_rd_data     = rd_burst_data;
  assign wr_burst_data   = wr_data_a[gnt_id];
  assign req_rd_valid    = (in_busy && dir_rd && rd_burst_data_valid) ? own : '0;
  assign req_wr_data_req = (in_busy && !dir_rd && wr_burst_data_req) ? own : '0;
  assign req_rd_finish   = ((in_busy && dir_rd && rd_burst_finish) || (in_zero && dir_rd)) ? own : '0;
  assign req_wr_finish   = ((in_busy && !dir_rd && wr_burst_finish) || (in_zero && !dir_rd)) ? own : '0;

endmodule
